data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single data port of the on-chip dual-port RAM between NUM_REQ requesters.
//  Requesters are the core LSU (index 0) and the debug/host loader (index 1).
//  Uses the req/gnt/rvalid protocol of the core data interface.
//  Arbitrates one access per cycle, forwards it to RAM, and routes each response back to its issuer.
//  Sits in top between the core data_* signals and the RAM data port.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  data width; BE width = DATA_WIDTH/8
//  RD_LATENCY  1   RAM cycles from accepted request to rdata valid (1..4)
//  FIXED_PRIO  0   0 = round-robin; 1 = fixed priority, lowest index wins
// PORTS
//  clk_i          in   1                    clock
//  rst_i          in   1                    synchronous reset, active-high
//  req_i          in   NUM_REQ              per-requester request
//  we_i           in   NUM_REQ              per-requester write enable
//  addr_i         in   NUM_REQ x ADDR_WIDTH request address
//  be_i           in   NUM_REQ x DATA_WIDTH/8 byte enables
//  wdata_i        in   NUM_REQ x DATA_WIDTH write data
//  gnt_o          out  NUM_REQ              one-hot grant, same cycle as request
//  rvalid_o       out  NUM_REQ              response valid to issuing requester
//  rdata_o        out  DATA_WIDTH           shared response data; qualify with rvalid_o[k]
//  mem_req_o      out  1                    RAM access strobe
//  mem_we_o       out  1                    RAM write enable
//  mem_addr_o     out  ADDR_WIDTH           RAM address
//  mem_be_o       out  DATA_WIDTH/8         RAM byte enables
//  mem_wdata_o    out  DATA_WIDTH           RAM write data
//  mem_rdata_i    in   DATA_WIDTH           RAM read data, RD_LATENCY cycles after mem_req_o
// BEHAVIOUR
//  - RAM accepts one access every cycle, so there is no back-pressure from the RAM side.
//  - Grant and RAM command are combinational from req_i:
//    mem_req_o = |req_i & ~rst_i; winner's we/addr/be/wdata are muxed to mem_*_o.
//    gnt_o has exactly one bit set when any req_i is set, otherwise 0.
//  - Round-robin: pointer rr_q names the highest-priority index.
//    Search is rr_q, rr_q+1, ... (mod NUM_REQ); first asserted req wins.
//    On a grant to k: rr_q <= (k+1) mod NUM_REQ. rr_q holds when there is no grant.
//  - FIXED_PRIO=1: rr_q is unused and the lowest asserted index wins.
//  - A requester holds req/we/addr/be/wdata stable until gnt. Ungranted requests stay pending; they are never dropped.
//  - Response tracking: shift pipe of RD_LATENCY stages, each {vld, id}.
//    Stage 0 loads {mem_req_o, winner}; each stage advances every cycle.
//    rvalid_o[id] = last-stage vld. Reads and writes both get exactly one rvalid.
//    rdata_o = mem_rdata_i unregistered; its value is don't-care for writes.
//  - Latency: gnt at cycle T -> rvalid at T+RD_LATENCY. One access in flight per cycle; full throughput.
//  - A grant and a response to the same requester in the same cycle are legal. Both are asserted.
//  - Reset (synchronous):
//    rr_q=0; all pipe vld=0; rvalid_o=0; gnt_o=0 and mem_req_o=0 while rst_i=1.
//    Reset mid-operation discards in-flight responses. No rvalid is produced for them.
//  - Assertions:
//    $onehot0(gnt_o); gnt_o subset of req_i; rvalid_o count == prior grant count per requester.
// STRUCTURE
//  - mem_arb_pkg: REQ_ID_W = $clog2(NUM_REQ); typedef mem_req_t {we, addr, be, wdata};
//    typedef rsp_tag_t {vld, id}.
//  - Sub-module rr_arbiter (req vector, rr pointer, FIXED_PRIO -> one-hot gnt + encoded id).
//    The top level holds rr_q, the command mux and the tag pipe.
// TESTING
//  1. Reset: rst_i=1 for 5 cycles with req_i=2'b11 -> gnt_o=0, mem_req_o=0, rvalid_o=0; after release rr_q=0 and req 0 wins first.
//  2. Single requester: core reads 0x100..0x10C on 4 back-to-back cycles -> gnt every cycle.
//     rvalid_o[0] follows 1 cycle later with RAM contents in order.
//  3. Contention: req_i=2'b11 held for 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid alternates one cycle behind.
//  4. FIXED_PRIO=1, req_i=2'b11 for 4 cycles -> gnt_o=2'b01 every cycle; requester 1 starves until req_i[0] drops.
//  5. Writes: host writes 0xDEADBEEF to 0x3FFFFC, be=4'hF.
//     -> mem_we_o=1 with that addr/data; rvalid_o[1] one cycle later; core read of 0x3FFFFC returns 0xDEADBEEF.
//  6. Reset mid-op: RD_LATENCY=3, grant at T, rst_i at T+1 -> no rvalid at T+3; next grant after reset is to index 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and defaults for the data-memory arbiter.
//   mem_req_t / rsp_tag_t describe the default (2 x 32-bit) configuration and
//   are the reference views of one RAM command and one response tag.
//   id_width() sizes requester-index fields for any NUM_REQ >= 2.
package mem_arb_pkg;

  localparam int NUM_REQ_DEF    = 2;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int RD_LATENCY_DEF = 1;
  localparam int REQ_ID_W       = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic                          we;
    logic [ADDR_WIDTH_DEF-1:0]     addr;
    logic [DATA_WIDTH_DEF/8-1:0]   be;
    logic [DATA_WIDTH_DEF-1:0]     wdata;
  } mem_req_t;

  typedef struct packed {
    logic                vld;
    logic [REQ_ID_W-1:0] id;
  } rsp_tag_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational request arbiter.
//   Round-robin search starts at i_ptr and wraps; with FIXED_PRIO != 0 the
//   search always starts at index 0 (lowest index wins) and i_ptr is ignored.
// Ports:
//   i_req  in  NUM_REQ  request vector
//   i_ptr  in  ID_W     highest-priority index (round-robin only)
//   o_gnt  out NUM_REQ  one-hot grant, zero when no request
//   o_id   out ID_W     encoded winner index, zero when no request
module rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_id
);

  logic w_found;

  // Index examined at search position 'off'.
  function automatic int slot(input int off, input int ptr);
    return (FIXED_PRIO != 0) ? off : (ptr + off) % NUM_REQ;
  endfunction

  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!w_found && i_req[slot(off, int'(i_ptr))]) begin
        w_found                     = 1'b1;
        o_gnt[slot(off, int'(i_ptr))] = 1'b1;
        o_id                        = ID_W'(slot(off, int'(i_ptr)));
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Purpose: shares the RAM data port between NUM_REQ requesters using the
//   req/gnt/rvalid protocol. One access is granted per cycle and forwarded
//   combinationally; a RD_LATENCY-deep tag pipe routes each response back.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   req_i/we_i/addr_i/be_i/wdata_i     per-requester command
//   gnt_o                              one-hot grant (same cycle as request)
//   rvalid_o, rdata_o                  response strobe per requester, shared data
//   mem_req_o/we/addr/be/wdata         RAM command
//   mem_rdata_i                        RAM read data, RD_LATENCY after mem_req_o
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_i,
  input  logic [NUM_REQ-1:0]                    we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  be_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_REQ-1:0]                    gnt_o,
  output logic [NUM_REQ-1:0]                    rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]               mem_be_o,
  output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i
);

  localparam int ID_W = id_width(NUM_REQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_id;
  logic [ID_W-1:0]    r_rr;
  tag_t               r_pipe [RD_LATENCY];

  rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .i_req (req_i),
    .i_ptr (r_rr),
    .o_gnt (w_gnt),
    .o_id  (w_id)
  );

  assign gnt_o       = rst_i ? '0 : w_gnt;
  assign mem_req_o   = (|req_i) & ~rst_i;
  assign mem_we_o    = we_i[w_id];
  assign mem_addr_o  = addr_i[w_id];
  assign mem_be_o    = be_i[w_id];
  assign mem_wdata_o = wdata_i[w_id];
  assign rdata_o     = mem_rdata_i;

  // Pointer moves just past the winner; held when nothing is granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= '0;
    end else if (|req_i) begin
      r_rr <= (w_id == ID_W'(NUM_REQ - 1)) ? '0 : w_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {mem_req_o, w_id};
      for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // A response landing in a reset cycle belongs to a discarded access.
  always_comb begin
    rvalid_o = '0;
    if (r_pipe[RD_LATENCY-1].vld && !rst_i) rvalid_o[r_pipe[RD_LATENCY-1].id] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(gnt_o));
      assert ((gnt_o & ~req_i) == '0);
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, rst3;
  logic [1:0]       req, we;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  be;

  logic [1:0]  gnt_a, rv_a, gnt_f, rv_f, gnt_l, rv_l;
  logic [31:0] rdata_a, rdata_f, rdata_l;
  logic        mreq_a, mwe_a, mreq_f, mwe_f, mreq_l, mwe_l;
  logic [31:0] maddr_a, mwdata_a, maddr_f, mwdata_f, maddr_l, mwdata_l;
  logic [3:0]  mbe_a, mbe_f, mbe_l;
  logic [31:0] mrdata_a;
  logic [31:0] mrdata_f = 32'h0;
  logic [31:0] mrdata_l = 32'h0;

  data_mem_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(0)) dut_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rdata_a),
    .mem_req_o(mreq_a), .mem_we_o(mwe_a), .mem_addr_o(maddr_a), .mem_be_o(mbe_a),
    .mem_wdata_o(mwdata_a), .mem_rdata_i(mrdata_a));

  data_mem_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_f), .rvalid_o(rv_f), .rdata_o(rdata_f),
    .mem_req_o(mreq_f), .mem_we_o(mwe_f), .mem_addr_o(maddr_f), .mem_be_o(mbe_f),
    .mem_wdata_o(mwdata_f), .mem_rdata_i(mrdata_f));

  data_mem_arbiter #(.RD_LATENCY(3), .FIXED_PRIO(0)) dut_l3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_l), .rvalid_o(rv_l), .rdata_o(rdata_l),
    .mem_req_o(mreq_l), .mem_we_o(mwe_l), .mem_addr_o(maddr_l), .mem_be_o(mbe_l),
    .mem_wdata_o(mwdata_l), .mem_rdata_i(mrdata_l));

  // RAM behind the round-robin instance: one-cycle read latency, byte-masked writes.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mreq_a) begin
      if (mwe_a) begin
        for (int b = 0; b < 4; b++)
          if (mbe_a[b]) ram[maddr_a[11:2]][8*b +: 8] <= mwdata_a[8*b +: 8];
      end else begin
        mrdata_a <= ram[maddr_a[11:2]];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  int          m_ptr, m_rv_id, last_w;
  logic        m_rv_rd;
  logic [31:0] m_rv_data;
  int          n_tests, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mem_req_t mk(input logic w, input logic [31:0] a, input logic [3:0] b,
                                  input logic [31:0] d);
    mem_req_t c;
    c.we = w; c.addr = a; c.be = b; c.wdata = d;
    return c;
  endfunction

  task automatic raise(input int k, input mem_req_t c);
    req[k] = 1'b1; we[k] = c.we; addr[k] = c.addr; be[k] = c.be; wdata[k] = c.wdata;
  endtask

  // First requester found searching from ptr with wrap-around, -1 if none.
  function automatic int pick(input logic [1:0] r, input int ptr);
    for (int off = 0; off < 2; off++)
      if (r[(ptr + off) % 2]) return (ptr + off) % 2;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (last_w >= 0) req[last_w] = 1'b0;
    last_w = -1;
  endtask

  // Check one cycle of the round-robin instance, then advance the model.
  task automatic step_rr(input string tag);
    int         w;
    logic [1:0] eg, erv;
    mem_req_t   c;
    #3;
    w   = pick(req, m_ptr);
    eg  = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
    erv = (m_rv_id < 0) ? 2'b00 : ((m_rv_id == 0) ? 2'b01 : 2'b10);
    chk({tag, ".gnt"}, gnt_a, eg);
    chk({tag, ".mem_req"}, mreq_a, (w >= 0));
    chk({tag, ".rvalid"}, rv_a, erv);
    if (m_rv_id >= 0 && m_rv_rd) chk({tag, ".rdata"}, rdata_a, m_rv_data);
    m_rv_id = w;
    m_rv_rd = 1'b0;
    if (w >= 0) begin
      c = mk(we[w], addr[w], be[w], wdata[w]);
      chk({tag, ".mem_we"}, mwe_a, c.we);
      chk({tag, ".mem_addr"}, maddr_a, c.addr);
      chk({tag, ".mem_be"}, mbe_a, c.be);
      if (c.we) begin
        chk({tag, ".mem_wdata"}, mwdata_a, c.wdata);
        for (int b = 0; b < 4; b++)
          if (c.be[b]) ref_mem[c.addr[11:2]][8*b +: 8] = c.wdata[8*b +: 8];
      end else begin
        m_rv_rd   = 1'b1;
        m_rv_data = ref_mem[c.addr[11:2]];
      end
      m_ptr = (w + 1) % 2;
    end
    last_w = w;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_ptr = 0; m_rv_id = -1; last_w = -1; m_rv_rd = 1'b0; m_rv_data = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = (i * 32'h0101_0101) ^ 32'hC0FF_EE00;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'hC0FF_EE00;
    end
    rst = 1'b1; rst3 = 1'b1;
    req = 2'b11; we = 2'b00; be = '1; wdata = '0;
    addr[0] = 32'h40; addr[1] = 32'h80;

    // Reset with both requesting
    repeat (5) begin
      tick(); #3;
      chk("rst.gnt", gnt_a, 2'b00);
      chk("rst.mem_req", mreq_a, 1'b0);
      chk("rst.rvalid", rv_a, 2'b00);
      chk("rst.fp_gnt", gnt_f, 2'b00);
      chk("rst.l3_mem_req", mreq_l, 1'b0);
    end
    tick();
    rst = 1'b0; rst3 = 1'b0;

    // Contention: alternating grants; fixed priority keeps granting index 0
    for (int i = 0; i < 6; i++) begin
      step_rr("cont");
      chk("cont.alt", gnt_a, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i < 4) chk("fp.gnt", gnt_f, 2'b01);
      tick();
      if (i < 5)
        for (int k = 0; k < 2; k++)
          if (!req[k]) raise(k, mk(1'b0, addr[k] + 32'h4, 4'hF, 32'h0));
    end
    step_rr("cont.tail");
    tick();
    raise(1, mk(1'b0, 32'h20, 4'hF, 32'h0));
    step_rr("starve_end");
    chk("fp.starve_end", gnt_f, 2'b10);
    tick();
    step_rr("idle");
    tick();

    // Single requester, back-to-back reads
    for (int i = 0; i < 4; i++) begin
      raise(0, mk(1'b0, 32'h100 + 32'(4 * i), 4'hF, 32'h0));
      step_rr("single");
      chk("single.gnt", gnt_a, 2'b01);
      tick();
    end
    step_rr("single.last");
    tick();

    // Host write then core read-back
    raise(1, mk(1'b1, 32'h003F_FFFC, 4'hF, 32'hDEAD_BEEF));
    step_rr("wr");
    chk("wr.mem_we", mwe_a, 1'b1);
    tick();
    raise(0, mk(1'b0, 32'h003F_FFFC, 4'hF, 32'h0));
    step_rr("rdback");
    chk("wr.rvalid", rv_a, 2'b10);
    tick();
    step_rr("rdback.rsp");
    chk("rdback.rvalid", rv_a, 2'b01);
    chk("rdback.data", rdata_a, 32'hDEAD_BEEF);
    tick();

    // Random traffic with hold-until-grant requesters
    repeat (300) begin
      for (int k = 0; k < 2; k++)
        if (!req[k] && $urandom_range(0, 2) != 0)
          raise(k, mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4),
                       4'($urandom), $urandom));
      step_rr("rand");
      tick();
    end
    repeat (4) begin
      step_rr("drain");
      tick();
    end

    // Mid-operation reset on the latency-3 instance
    raise(0, mk(1'b0, 32'h10, 4'hF, 32'h0));
    step_rr("t6.T");
    chk("t6.gnt_T", gnt_l, 2'b01);
    tick();
    rst3 = 1'b1;
    step_rr("t6.T1");
    chk("t6.rvalid_T1", rv_l, 2'b00);
    tick();
    rst3 = 1'b0;
    raise(0, mk(1'b0, 32'h14, 4'hF, 32'h0));
    raise(1, mk(1'b0, 32'h18, 4'hF, 32'h0));
    step_rr("t6.T2");
    chk("t6.gnt_after_rst", gnt_l, 2'b01);
    chk("t6.rvalid_T2", rv_l, 2'b00);
    tick();
    for (int k = 0; k < 2; k++)
      if (!req[k]) raise(k, mk(1'b0, 32'h1C, 4'hF, 32'h0));
    step_rr("t6.T3");
    chk("t6.no_rvalid_T3", rv_l, 2'b00);
    chk("t6.gnt_T3", gnt_l, 2'b10);
    tick();
    step_rr("t6.T4");
    chk("t6.rvalid_T4", rv_l, 2'b00);
    tick();
    step_rr("t6.T5");
    chk("t6.rvalid_T5", rv_l, 2'b01);
    tick();
    step_rr("t6.T6");
    chk("t6.rvalid_T6", rv_l, 2'b10);
    tick();
    repeat (3) begin
      step_rr("t6.drain");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
